// File: rtl/reloj_mascota.sv
// Time-of-day counter for the pet game: seconds/minutes/hours/day driven by the
// rising edges of the divider's tick, with load, pause, demo acceleration and rollover strobes.
module reloj_mascota #(
    parameter int INIT_HORA = 8,
    parameter int DIA_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             acelerar,
    input  logic             pausa,
    input  logic             cargar,
    input  logic [4:0]       hora_in,
    input  logic [5:0]       min_in,
    output logic [5:0]       seg,
    output logic [5:0]       minuto,
    output logic [4:0]       hora,
    output logic [DIA_W-1:0] dia,
    output logic             pulso_seg,
    output logic             pulso_min,
    output logic             pulso_hora,
    output logic             pulso_dia
);

    localparam logic [4:0] HORA_RST = 5'(INIT_HORA);

    logic             tick_d;
    logic             evento;
    logic             inc_min;
    logic             inc_hora;
    logic [5:0]       seg_n;
    logic [5:0]       minuto_n;
    logic [4:0]       hora_n;
    logic [DIA_W-1:0] dia_n;
    logic             p_seg_n;
    logic             p_min_n;
    logic             p_hora_n;
    logic             p_dia_n;

    assign evento = tick_in & ~tick_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        seg_n    = seg;
        minuto_n = minuto;
        hora_n   = hora;
        dia_n    = dia;
        p_seg_n  = 1'b0;
        p_min_n  = 1'b0;
        p_hora_n = 1'b0;
        p_dia_n  = 1'b0;
        inc_min  = 1'b0;
        inc_hora = 1'b0;

        if (cargar) begin
            hora_n   = (hora_in > 5'd23) ? 5'd23 : hora_in;
            minuto_n = (min_in > 6'd59) ? 6'd59 : min_in;
            seg_n    = 6'd0;
        end else if (!pausa && evento) begin
            // In demo mode a tick is worth a whole minute; seconds stay put.
            if (acelerar) begin
                inc_min = 1'b1;
            end else begin
                p_seg_n = 1'b1;
                if (seg == 6'd59) begin
                    seg_n   = 6'd0;
                    inc_min = 1'b1;
                end else begin
                    seg_n = seg + 6'd1;
                end
            end

            if (inc_min) begin
                p_min_n = 1'b1;
                if (minuto == 6'd59) begin
                    minuto_n = 6'd0;
                    inc_hora = 1'b1;
                end else begin
                    minuto_n = minuto + 6'd1;
                end
            end

            if (inc_hora) begin
                p_hora_n = 1'b1;
                if (hora == 5'd23) begin
                    hora_n  = 5'd0;
                    dia_n   = dia + DIA_W'(1);
                    p_dia_n = 1'b1;
                end else begin
                    hora_n = hora + 5'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_d     <= 1'b0;
            seg        <= 6'd0;
            minuto     <= 6'd0;
            hora       <= HORA_RST;
            dia        <= '0;
            pulso_seg  <= 1'b0;
            pulso_min  <= 1'b0;
            pulso_hora <= 1'b0;
            pulso_dia  <= 1'b0;
        end else begin
            tick_d     <= tick_in;
            seg        <= seg_n;
            minuto     <= minuto_n;
            hora       <= hora_n;
            dia        <= dia_n;
            pulso_seg  <= p_seg_n;
            pulso_min  <= p_min_n;
            pulso_hora <= p_hora_n;
            pulso_dia  <= p_dia_n;
        end
    end

endmodule
